// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES request scheduler.
package aes_sched_pkg;

  localparam int unsigned BlockW  = 128;
  // Widest channel index the scheduler supports (up to 8 requesters).
  localparam int unsigned ChMaxW  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StKload,
    StKwait,
    StLoad,
    StBusy,
    StPush
  } state_e;

  typedef struct packed {
    logic [BlockW-1:0] text;
    logic [ChMaxW-1:0] ch;
  } rsp_entry_t;

endpackage

// File: rtl/aes_sched_if.sv
// Pin bundle of the AES core; the scheduler drives it, the core answers it.
interface aes_sched_if;
  import aes_sched_pkg::*;

  logic              core_ld;
  logic              core_kld;
  logic [BlockW-1:0] core_key;
  logic [BlockW-1:0] core_text_in;
  logic              core_kdone;
  logic              core_done;
  logic [BlockW-1:0] core_text_out;

  modport master (
    output core_ld, core_kld, core_key, core_text_in,
    input  core_kdone, core_done, core_text_out
  );

  modport slave (
    input  core_ld, core_kld, core_key, core_text_in,
    output core_kdone, core_done, core_text_out
  );

endinterface

// File: rtl/aes_sched_fifo.sv
// Response FIFO; read data reads as zero while empty so outputs are clean after reset.
module aes_sched_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             wr, rd;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign wr        = wr_en_i && !full_o;
  assign rd        = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[PtrW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/aes_sched.sv
// Round-robin scheduler sharing one AES core among NCH requesters, with key
// reload tracking, a completion timeout and an ordered response FIFO.
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned ChW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NCH-1:0]               req_valid,
  output logic [NCH-1:0]               req_ready,
  input  logic [NCH-1:0][BlockW-1:0]   req_key,
  input  logic [NCH-1:0][BlockW-1:0]   req_text,
  input  logic [NCH-1:0]               req_newkey,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [BlockW-1:0]            rsp_text,
  output logic [ChW-1:0]               rsp_ch,
  output logic                         err_timeout,
  aes_sched_if.master                  core
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ChW-1:0]    rr_q, rr_d, key_ch_q, key_ch_d, cap_ch_q, cap_ch_d, gnt_ch;
  logic              key_vld_q, key_vld_d, err_q, err_d;
  logic [BlockW-1:0] cap_key_q, cap_key_d, cap_text_q, cap_text_d, res_q, res_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              gnt_found, gnt_ok, fifo_full, fifo_empty, fifo_wr;
  rsp_entry_t        wr_entry, rd_entry;
  logic              unused_ch;
  int unsigned       idx;

  // Search starts at rr_q, the channel after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (32'(rr_q) + i) % NCH;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = ChW'(idx);
      end
    end
  end

  assign gnt_ok = (state_q == StIdle) && gnt_found && !fifo_full && !rst;

  always_comb begin
    req_ready = '0;
    if (gnt_ok) req_ready[gnt_ch] = 1'b1;
  end

  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    key_ch_d         = key_ch_q;
    key_vld_d        = key_vld_q;
    cap_ch_d         = cap_ch_q;
    cap_key_d        = cap_key_q;
    cap_text_d       = cap_text_q;
    res_d            = res_q;
    err_d            = err_q;
    cnt_d            = cnt_q;
    cnt_inc          = cnt_q + 1'b1;
    fifo_wr          = 1'b0;
    core.core_ld     = 1'b0;
    core.core_kld    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_ok) begin
          cap_ch_d   = gnt_ch;
          cap_key_d  = req_key[gnt_ch];
          cap_text_d = req_text[gnt_ch];
          rr_d       = (gnt_ch == ChW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
          state_d    = (req_newkey[gnt_ch] || !key_vld_q || key_ch_q != gnt_ch) ?
                       StKload : StLoad;
        end
      end
      StKload: begin
        core.core_kld = 1'b1;
        cnt_d         = '0;
        state_d       = StKwait;
      end
      StKwait: begin
        if (core.core_kdone) begin
          key_ch_d  = cap_ch_q;
          key_vld_d = 1'b1;
          state_d   = StLoad;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TIMEOUT)) begin
            err_d     = 1'b1;
            key_vld_d = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      StLoad: begin
        core.core_ld = 1'b1;
        cnt_d        = '0;
        state_d      = StBusy;
      end
      StBusy: begin
        if (core.core_done) begin
          res_d   = core.core_text_out;
          state_d = StPush;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TIMEOUT)) begin
            err_d     = 1'b1;
            key_vld_d = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      StPush: begin
        fifo_wr = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      key_ch_q   <= '0;
      key_vld_q  <= 1'b0;
      cap_ch_q   <= '0;
      cap_key_q  <= '0;
      cap_text_q <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      key_ch_q   <= key_ch_d;
      key_vld_q  <= key_vld_d;
      cap_ch_q   <= cap_ch_d;
      cap_key_q  <= cap_key_d;
      cap_text_q <= cap_text_d;
      res_q      <= res_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign core.core_key     = cap_key_q;
  assign core.core_text_in = cap_text_q;
  assign err_timeout       = err_q;

  assign wr_entry.text = res_q;
  assign wr_entry.ch   = ChMaxW'(cap_ch_q);

  aes_sched_fifo #(
    .Depth (DEPTH),
    .Width ($bits(rsp_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (wr_entry),
    .rd_en_i   (rsp_ready),
    .rd_data_o (rd_entry),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_text  = rd_entry.text;
  assign rsp_ch    = rd_entry.ch[ChW-1:0];
  assign unused_ch = ^rd_entry.ch;

endmodule

// File: tb/tb_aes_sched.sv
// Scoreboard bench for aes_sched with a behavioural AES core stand-in.
module tb_aes_sched;
  import aes_sched_pkg::*;

  localparam int unsigned NCH     = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int          KLAT    = 3;
  localparam int          LAT     = 5;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [127:0] text;
    int           ch;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NCH-1:0]        req_valid = '0;
  logic [NCH-1:0]        req_ready;
  logic [NCH-1:0][127:0] req_key = '0;
  logic [NCH-1:0][127:0] req_text = '0;
  logic [NCH-1:0]        req_newkey = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [127:0]          rsp_text;
  logic [0:0]            rsp_ch;
  logic                  err_timeout;

  aes_sched_if core_bus ();

  aes_sched #(
    .NCH     (NCH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_key     (req_key),
    .req_text    (req_text),
    .req_newkey  (req_newkey),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_text    (rsp_text),
    .rsp_ch      (rsp_ch),
    .err_timeout (err_timeout),
    .core        (core_bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  int   gnt_log[$];
  int   ev_log[$];
  int   gnt_total = 0;
  int   kld_cnt = 0;
  int   ld_cnt = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Stand-in cipher: real vector for the FIPS-197 case, a keyed mix otherwise.
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  // Behavioural core
  logic [127:0] m_key = '0, m_text = '0, m_out = '0;
  int           kcnt = 0, dcnt = 0;
  logic         m_kdone = 1'b0, m_done = 1'b0, stray_done = 1'b0, done_en = 1'b1;

  assign core_bus.core_kdone    = m_kdone;
  assign core_bus.core_done     = m_done | stray_done;
  assign core_bus.core_text_out = m_out;

  always @(posedge clk) begin
    m_kdone <= 1'b0;
    m_done  <= 1'b0;
    if (kcnt > 0) begin
      kcnt <= kcnt - 1;
      if (kcnt == 1) m_kdone <= 1'b1;
    end
    if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && done_en) begin
        m_done <= 1'b1;
        m_out  <= cipher(m_key, m_text);
      end
    end
    if (core_bus.core_kld) begin
      m_key <= core_bus.core_key;
      kcnt  <= KLAT;
    end
    if (core_bus.core_ld) begin
      m_text <= core_bus.core_text_in;
      dcnt   <= LAT;
    end
  end

  // Monitor: grants push expectations, pops compare responses.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_q.push_back('{text: cipher(req_key[i], req_text[i]), ch: i});
          gnt_log.push_back(i);
          gnt_total <= gnt_total + 1;
        end
      end
      if (core_bus.core_kld) begin
        kld_cnt <= kld_cnt + 1;
        ev_log.push_back(1);
      end
      if (core_bus.core_ld) begin
        ld_cnt <= ld_cnt + 1;
        ev_log.push_back(2);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("rsp_unexpected", 128'(rsp_valid), 128'(0));
        end else begin
          check_eq("rsp_text", rsp_text, sb_q[0].text);
          check_eq("rsp_ch", 128'(rsp_ch), 128'(sb_q[0].ch));
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic wait_gnt(input int target, input string tag);
    int n = 0;
    while (gnt_total < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 128'(gnt_total >= target), 128'(1));
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || rsp_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 128'(sb_q.size() == 0 && !rsp_valid), 128'(1));
  endtask

  task automatic wait_ld(input string tag);
    int n = 0;
    while (!core_bus.core_ld && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 128'(core_bus.core_ld), 128'(1));
  endtask

  task automatic send(input int ch, input logic [127:0] k, input logic [127:0] t,
                      input logic nk);
    int g0 = gnt_total;
    req_key[ch]    = k;
    req_text[ch]   = t;
    req_newkey[ch] = nk;
    req_valid[ch]  = 1'b1;
    wait_gnt(g0 + 1, "send_gnt");
    req_valid[ch]  = 1'b0;
    req_newkey[ch] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int g0, k0, l0, e0, b0;

    // Reset state, with requests pending to prove grants are held off
    rst       = 1'b1;
    req_valid = '1;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check_eq("rst_req_ready", 128'(req_ready), 128'(0));
    check_eq("rst_core_ld", 128'(core_bus.core_ld), 128'(0));
    check_eq("rst_core_kld", 128'(core_bus.core_kld), 128'(0));
    check_eq("rst_err", 128'(err_timeout), 128'(0));
    check_eq("rst_rsp_text", rsp_text, 128'(0));
    check_eq("rst_rsp_ch", 128'(rsp_ch), 128'(0));
    check_eq("rst_core_key", core_bus.core_key, 128'(0));
    check_eq("rst_core_text", core_bus.core_text_in, 128'(0));
    check_eq("rst_state", 128'(dut.state_q), 128'(StIdle));
    req_valid = '0;
    rst       = 1'b0;

    // FIPS-197 vector on ch0: key load precedes the block load
    k0 = kld_cnt; l0 = ld_cnt; e0 = ev_log.size();
    send(0, FIPS_KEY, FIPS_PT, 1'b0);
    wait_drain("fips_drain");
    check_eq("fips_kld", 128'(kld_cnt - k0), 128'(1));
    check_eq("fips_ld", 128'(ld_cnt - l0), 128'(1));
    check_eq("fips_ev0_kld", 128'(ev_log[e0]), 128'(1));
    check_eq("fips_ev1_ld", 128'(ev_log[e0 + 1]), 128'(2));

    // Back-to-back ch0 with one key: one reload, two loads, in-order results
    do_reset();
    k0 = kld_cnt; l0 = ld_cnt; g0 = gnt_total;
    req_key[0]   = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    req_text[0]  = 128'h3243f6a8_885a308d_313198a2_e0370734;
    req_valid[0] = 1'b1;
    wait_gnt(g0 + 1, "b2b_gnt1");
    req_text[0]  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    wait_gnt(g0 + 2, "b2b_gnt2");
    req_valid[0] = 1'b0;
    wait_drain("b2b_drain");
    check_eq("b2b_kld", 128'(kld_cnt - k0), 128'(1));
    check_eq("b2b_ld", 128'(ld_cnt - l0), 128'(2));

    // Round-robin with both channels always valid
    do_reset();
    k0 = kld_cnt; g0 = gnt_total; b0 = gnt_log.size();
    req_key[0]  = 128'h11111111_22222222_33333333_44444444;
    req_text[0] = 128'haaaa0000_bbbb1111_cccc2222_dddd3333;
    req_key[1]  = 128'h55555555_66666666_77777777_88888888;
    req_text[1] = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    req_valid   = '1;
    wait_gnt(g0 + 4, "rr_gnt");
    req_valid   = '0;
    wait_drain("rr_drain");
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rr_order%0d", i), 128'(gnt_log[b0 + i]), 128'(i % 2));
    end
    check_eq("rr_kld", 128'(kld_cnt - k0), 128'(4));

    // FIFO full: grants stop at DEPTH until responses drain
    do_reset();
    g0 = gnt_total;
    rsp_ready    = 1'b0;
    req_key[0]   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    req_text[0]  = 128'hffeeddcc_bbaa9988_77665544_33221100;
    req_valid[0] = 1'b1;
    wait_gnt(g0 + 4, "full_gnt4");
    repeat (60) @(negedge clk);
    check_eq("full_gnt_held", 128'(gnt_total - g0), 128'(4));
    check_eq("full_req_ready", 128'(req_ready), 128'(0));
    check_eq("full_rsp_valid", 128'(rsp_valid), 128'(1));
    rsp_ready = 1'b1;
    wait_gnt(g0 + 6, "full_gnt6");
    req_valid[0] = 1'b0;
    wait_drain("full_drain");
    check_eq("full_total", 128'(gnt_total - g0), 128'(6));

    // Timeout: core never completes
    do_reset();
    done_en = 1'b0;
    send(0, 128'hcafe_babe_0000_1111_2222_3333_4444_5555, 128'h77, 1'b0);
    wait_ld("tmo_ld");
    repeat (TIMEOUT - 1) @(negedge clk);
    check_eq("tmo_err_early", 128'(err_timeout), 128'(0));
    repeat (2) @(negedge clk);
    check_eq("tmo_err", 128'(err_timeout), 128'(1));
    check_eq("tmo_state", 128'(dut.state_q), 128'(StIdle));
    check_eq("tmo_no_rsp", 128'(rsp_valid), 128'(0));
    check_eq("tmo_sb", 128'(sb_q.size()), 128'(1));
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("stray_no_rsp", 128'(rsp_valid), 128'(0));
    done_en = 1'b1;
    k0 = kld_cnt;
    send(0, 128'hcafe_babe_0000_1111_2222_3333_4444_5555, 128'h77, 1'b0);
    wait_drain("tmo_next_drain");
    check_eq("tmo_next_kld", 128'(kld_cnt - k0), 128'(1));
    check_eq("tmo_err_sticky", 128'(err_timeout), 128'(1));

    // Reset in BUSY, then a late core_done
    done_en = 1'b0;
    send(1, 128'h1234, 128'h5678, 1'b0);
    wait_ld("mid_ld");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_rsp_valid", 128'(rsp_valid), 128'(0));
    check_eq("mid_state", 128'(dut.state_q), 128'(StIdle));
    check_eq("mid_err_clr", 128'(err_timeout), 128'(0));
    repeat (80) @(negedge clk);
    check_eq("mid_still_empty", 128'(rsp_valid), 128'(0));
    check_eq("mid_no_tmo", 128'(err_timeout), 128'(0));
    done_en = 1'b1;

    check_eq("sb_final", 128'(sb_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
